// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the round-robin ROM arbiter and its picker.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int                   CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = 16'hFFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the search starts one past last_grant and wraps.
// Zero latency; grant is all-zero when no request is pending.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  // Walk priorities from lowest to highest so the highest-priority match is written last.
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && (i == ((int'(last_grant) + k) % NUM_REQ))) begin
          grant    = '0;
          grant[i] = 1'b1;
          winner   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one combinational ROM; request-to-response latency 2 cycles,
// one transaction in flight, response held until rsp_ready. ROM_ARB_STATS_EN adds grant_cnt.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_q
`ifdef ROM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        last_grant;
  logic [IDX_W-1:0]        cur_id;
  logic [IDX_W-1:0]        win_idx;
  logic [NUM_REQ-1:0]      win_grant;
  logic [ADDR_WIDTH-1:0]   win_addr;
  logic                    req_hs;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (win_grant),
    .winner     (win_idx)
  );

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_grant[i]) win_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // The picker only ever grants a valid requester, so any grant in IDLE is a handshake.
  assign req_hs = (state_q == IDLE) && (|win_grant);

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        req_ready = win_grant;
        if (|win_grant) state_d = READ;
      end
      READ: state_d = RESP;
      RESP: begin
        rsp_valid[cur_id] = 1'b1;
        if (rsp_ready[cur_id]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cur_id     <= '0;
      rom_addr   <= '0;
      rsp_data   <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        last_grant <= win_idx;
        cur_id     <= win_idx;
        rom_addr   <= win_addr;
      end
      if (state_q == READ) rsp_data <= rom_q;
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_hs && win_grant[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule
